marquee_ctrl: RTL

MARQUEE_CTRL -- requirements
Module: marquee_ctrl

---
 rtl/marquee_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/marquee_ctrl.sv
// Marquee controller: debounced buttons drive an EDIT/RUN/HOLD FSM that
// builds a digit sequence and gates the downstream shift enable/direction.
module marquee_ctrl #(
  parameter int N      = 32,
  parameter int WIDTH  = 4,
  parameter int DB_CNT = 1_000_000
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      btn_load,
  input  logic                      btn_run,
  input  logic                      btn_dir,
  input  logic                      btn_clr,
  input  logic [WIDTH-1:0]          digit,
  output logic [N-1:0]              seq,
  output logic                      enable,
  output logic                      dir,
  output logic [$clog2(N/WIDTH):0]  digit_cnt,
  output logic [1:0]                state
);

  localparam int NB    = 4;
  localparam int CNT_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam int DC_W  = $clog2(N/WIDTH) + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CNT - 1);
  localparam logic [DC_W-1:0]  MAX_D   = DC_W'(N / WIDTH);

  typedef enum logic [1:0] {
    EDIT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t cur_state;

  // Button order in every vector: [0]=load, [1]=run, [2]=dir, [3]=clr
  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync_1;
  logic [NB-1:0]    sync_2;
  logic [NB-1:0]    db_lvl;
  logic [NB-1:0]    db_prev;
  logic [NB-1:0]    armed;
  logic [NB-1:0]    pulse;
  logic [1:0]       sync_valid;
  logic [CNT_W-1:0] db_cnt [NB];

  logic load_p, run_p, dir_p, clr_p;

  assign raw    = {btn_clr, btn_dir, btn_run, btn_load};
  assign load_p = pulse[0];
  assign run_p  = pulse[1];
  assign dir_p  = pulse[2];
  assign clr_p  = pulse[3];

  // sync_valid marks when sync_2 holds a real sample rather than reset zeros.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_1     <= '0;
      sync_2     <= '0;
      sync_valid <= '0;
    end else begin
      sync_1     <= raw;
      sync_2     <= sync_1;
      sync_valid <= {sync_valid[0], 1'b1};
    end
  end

  // A button only arms once it has been seen released after reset, so a key
  // held through reset release cannot fire until it is pressed again.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      db_lvl  <= '0;
      db_prev <= '0;
      armed   <= '0;
      pulse   <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      db_prev <= db_lvl;
      for (int i = 0; i < NB; i++) begin
        if (sync_2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync_2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
        if (sync_valid[1] && !sync_2[i]) armed[i] <= 1'b1;
        pulse[i] <= db_lvl[i] & ~db_prev[i] & armed[i];
      end
    end
  end

  // Control FSM; clr beats run beats load, dir toggles independently.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cur_state <= EDIT;
      enable    <= 1'b0;
      dir       <= 1'b0;
      seq       <= '0;
      digit_cnt <= '0;
    end else begin
      if (dir_p) dir <= ~dir;
      if (clr_p) begin
        cur_state <= EDIT;
        enable    <= 1'b0;
        seq       <= '0;
        digit_cnt <= '0;
      end else if (run_p) begin
        case (cur_state)
          EDIT: begin
            cur_state <= RUN;
            enable    <= 1'b1;
          end
          RUN: begin
            cur_state <= HOLD;
            enable    <= 1'b0;
          end
          default: begin
            cur_state <= RUN;
            enable    <= 1'b1;
          end
        endcase
      end else if (load_p && cur_state == EDIT) begin
        seq <= {seq[N-WIDTH-1:0], digit};
        if (digit_cnt != MAX_D) digit_cnt <= digit_cnt + DC_W'(1);
      end
    end
  end

  assign state = cur_state;

endmodule
